control_seq: RTL and testbench

- Multi-cycle control unit for the picoMips core.
- Stage is sequenced internally rather than driven from outside.
- Latches the fetched instruction, decodes its function field, and generates datapath selects and write enables qualified by stage.
- Adds a synchronised, optionally time-bounded handshake-wait instruction (HEI) that stalls the PC.
- Sits between program memory and the register file / ALU / accumulator.

---
 rtl/control_pkg.sv | 55 +++++
 rtl/handshake_sync.sv | 31 +++
 rtl/control_seq.sv | 155 +++++++++++++++
 tb/tb_control_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// -----------------------------------------------------------------------------
// control_pkg
// Shared types and constants for the picoMips multi-cycle control unit.
//   stage_t     : internal sequencer states (WAIT is the handshake stall)
//   stage_code  : maps a state to the 2-bit Stage output (WAIT reports EXEC)
//   F_*         : bit positions inside the 6-bit function field
//   sign_extend : sign-extends the low src_w bits of a SEXT_W-wide value
// -----------------------------------------------------------------------------
package control_pkg;

    localparam int FUNC_W = 6;

    localparam int F_USEA   = 0;
    localparam int F_SELSW  = 1;
    localparam int F_SELIMM = 2;
    localparam int F_USEMUL = 3;
    localparam int F_REGWR  = 4;
    localparam int F_SELREG = 5;

    // Widest immediate the sign-extend helper can produce.
    localparam int SEXT_W = 64;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        WAIT   = 3'd4
    } stage_t;

    function automatic logic [1:0] stage_code(input stage_t s);
        logic [1:0] code;
        unique case (s)
            FETCH:   code = 2'd0;
            DECODE:  code = 2'd1;
            EXEC:    code = 2'd2;
            WB:      code = 2'd3;
            WAIT:    code = 2'd2;  // a stalled HEI still looks like EXEC
            default: code = 2'd0;
        endcase
        return code;
    endfunction

    // Bits at or above src_w are replaced by copies of bit src_w-1.
    function automatic logic [SEXT_W-1:0] sign_extend(input logic [SEXT_W-1:0] value,
                                                      input int               src_w);
        logic [SEXT_W-1:0] result;
        result = '0;
        for (int i = 0; i < SEXT_W; i++) begin
            result[i] = (i < src_w) ? value[i] : value[src_w-1];
        end
        return result;
    endfunction

endpackage

// File: rtl/handshake_sync.sv
// -----------------------------------------------------------------------------
// handshake_sync
// Multi-flop synchroniser bringing the asynchronous Handshake level into the
// Clock domain.
//   Clock     in  system clock, rising edge
//   Reset     in  asynchronous active-high reset, clears every flop
//   Handshake in  asynchronous level
//   hs_sync   out Handshake delayed by SYNC_STAGES flops
// -----------------------------------------------------------------------------
module handshake_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Handshake,
    output logic hs_sync
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], Handshake};
        end
    end

    assign hs_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/control_seq.sv
// -----------------------------------------------------------------------------
// control_seq
// Multi-cycle control unit for the picoMips core. Sequences FETCH, DECODE,
// EXEC and WB internally, latches the fetched instruction and decodes its
// function field into datapath selects and stage-qualified write enables.
// The HEI instruction (func[5] & func[2]) stalls in WAIT until the
// synchronised handshake differs from IR[0], or until WAIT_TIMEOUT cycles
// have elapsed when WAIT_TIMEOUT > 0.
//   Clock        in  system clock, rising edge
//   Reset        in  asynchronous active-high reset
//   Instruction  in  program memory word, captured at the end of FETCH
//   Handshake    in  asynchronous handshake level
//   Stage        out 0 FETCH, 1 DECODE, 2 EXEC/WAIT, 3 WB
//   Immediate    out sign-extended operand field of IR
//   PCEn         out PC advance, high for the WB cycle only
//   RegWrite     out register file write enable (WB, non-HEI, func[4])
//   ACCWE        out accumulator write enable (EXEC, non-HEI)
//   RegAddr      out IR[REG_AW-1:0]
//   SelImm, SelSW, UseMul, UseA, SelReg  out  datapath selects from IR
//   Waiting      out high while stalled in WAIT
//   TimedOut     out high during the WB cycle that follows a timed-out wait
// -----------------------------------------------------------------------------
module control_seq
    import control_pkg::*;
#(
    parameter int INSTR_W      = 12,
    parameter int DATA_W       = 8,
    parameter int REG_AW       = 1,
    parameter int SYNC_STAGES  = 2,
    parameter int WAIT_TIMEOUT = 0
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [INSTR_W-1:0] Instruction,
    input  logic               Handshake,
    output logic [1:0]         Stage,
    output logic [DATA_W-1:0]  Immediate,
    output logic               PCEn,
    output logic               RegWrite,
    output logic               ACCWE,
    output logic [REG_AW-1:0]  RegAddr,
    output logic               SelImm,
    output logic               SelSW,
    output logic               UseMul,
    output logic               UseA,
    output logic               SelReg,
    output logic               Waiting,
    output logic               TimedOut
);

    localparam int OPND_W     = INSTR_W - FUNC_W;
    localparam bit TIMEOUT_EN = (WAIT_TIMEOUT > 0);
    localparam int CNT_W      = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
    // Counter value seen on the last permitted WAIT cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

    stage_t             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timed_out_q, timed_out_d;

    logic [FUNC_W-1:0]  func;
    logic               is_hei;
    logic               hs_sync;
    logic               hs_met;
    logic               timeout_hit;

    handshake_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_handshake_sync (
        .Clock    (Clock),
        .Reset    (Reset),
        .Handshake(Handshake),
        .hs_sync  (hs_sync)
    );

    assign func        = ir_q[INSTR_W-1 -: FUNC_W];
    assign is_hei      = func[F_SELREG] & func[F_SELIMM];
    // HEI waits for the synchronised handshake to move away from its argument.
    assign hs_met      = (hs_sync != ir_q[0]);
    assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= FETCH;
            ir_q        <= '0;
            cnt_q       <= '0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            cnt_q       <= cnt_d;
            timed_out_q <= timed_out_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        cnt_d       = cnt_q;
        timed_out_d = 1'b0;

        unique case (state_q)
            FETCH: begin
                ir_d    = Instruction;
                state_d = DECODE;
            end
            DECODE: begin
                state_d = EXEC;
            end
            EXEC: begin
                if (is_hei) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end else begin
                    state_d = WB;
                end
            end
            WAIT: begin
                // Handshake is tested first so it wins a tie with the limit.
                if (hs_met) begin
                    state_d = WB;
                end else if (timeout_hit) begin
                    state_d     = WB;
                    timed_out_d = 1'b1;
                end else if (TIMEOUT_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WB: begin
                state_d = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign Stage     = stage_code(state_q);
    assign Immediate = DATA_W'(sign_extend(SEXT_W'(ir_q[OPND_W-1:0]), OPND_W));
    assign RegAddr   = ir_q[REG_AW-1:0];

    assign UseA      = func[F_USEA];
    assign SelSW     = func[F_SELSW];
    assign SelImm    = func[F_SELIMM];
    assign UseMul    = func[F_USEMUL];
    assign SelReg    = func[F_SELREG];

    assign ACCWE     = (state_q == EXEC) && !is_hei;
    assign RegWrite  = func[F_REGWR] && (state_q == WB) && !is_hei;
    assign PCEn      = (state_q == WB);
    assign Waiting   = (state_q == WAIT);
    assign TimedOut  = timed_out_q;

endmodule

// File: tb/tb_control_seq.sv
// -----------------------------------------------------------------------------
// tb_control_seq
// Two instances share clock and reset: dut0 (DATA_W 8, unbounded wait) and
// dut1 (DATA_W 16, WAIT_TIMEOUT 8), each with its own Instruction and
// Handshake drive. Per-cycle expectations for an instruction are queued when
// it is issued and popped on each falling edge while it executes.
// -----------------------------------------------------------------------------
module tb_control_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [11:0] instr_drv [2];
    logic        hs_drv    [2];

    logic [1:0]  stage0, stage1;
    logic [7:0]  imm0;
    logic [15:0] imm1;
    logic        pcen0, rw0, accwe0, pcen1, rw1, accwe1;
    logic [0:0]  ra0, ra1;
    logic        selimm0, selsw0, usemul0, usea0, selreg0, wait0, to0;
    logic        selimm1, selsw1, usemul1, usea1, selreg1, wait1, to1;

    control_seq #(
        .INSTR_W(12), .DATA_W(8), .REG_AW(1), .SYNC_STAGES(2), .WAIT_TIMEOUT(0)
    ) dut0 (
        .Clock(clk), .Reset(rst), .Instruction(instr_drv[0]), .Handshake(hs_drv[0]),
        .Stage(stage0), .Immediate(imm0), .PCEn(pcen0), .RegWrite(rw0), .ACCWE(accwe0),
        .RegAddr(ra0), .SelImm(selimm0), .SelSW(selsw0), .UseMul(usemul0), .UseA(usea0),
        .SelReg(selreg0), .Waiting(wait0), .TimedOut(to0)
    );

    control_seq #(
        .INSTR_W(12), .DATA_W(16), .REG_AW(1), .SYNC_STAGES(2), .WAIT_TIMEOUT(8)
    ) dut1 (
        .Clock(clk), .Reset(rst), .Instruction(instr_drv[1]), .Handshake(hs_drv[1]),
        .Stage(stage1), .Immediate(imm1), .PCEn(pcen1), .RegWrite(rw1), .ACCWE(accwe1),
        .RegAddr(ra1), .SelImm(selimm1), .SelSW(selsw1), .UseMul(usemul1), .UseA(usea1),
        .SelReg(selreg1), .Waiting(wait1), .TimedOut(to1)
    );

    typedef struct packed {
        logic [1:0]  stage;
        logic [15:0] imm;
        logic        pcen;
        logic        rw;
        logic        accwe;
        logic        ra;
        logic [4:0]  sel;      // {SelReg, UseMul, SelImm, SelSW, UseA}
        logic        waiting;
        logic        to;
    } obs_t;

    typedef struct {
        logic [1:0] stage;
        logic       pcen;
        logic       rw;
        logic       accwe;
        logic       waiting;
        logic       to;
    } exp_t;

    obs_t obs [2];
    exp_t exp_q [$];

    always_comb begin
        obs[0] = '{stage: stage0, imm: {8'h00, imm0}, pcen: pcen0, rw: rw0, accwe: accwe0,
                   ra: ra0[0], sel: {selreg0, usemul0, selimm0, selsw0, usea0},
                   waiting: wait0, to: to0};
        obs[1] = '{stage: stage1, imm: imm1, pcen: pcen1, rw: rw1, accwe: accwe1,
                   ra: ra1[0], sel: {selreg1, usemul1, selimm1, selsw1, usea1},
                   waiting: wait1, to: to1};
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Advance until dut d is in FETCH (called at posedge+1).
    task automatic align(input int d);
        int k;
        k = 0;
        while (obs[d].stage != 2'd0 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk($sformatf("align dut%0d", d), 32'(k < 20), 32'd1);
    endtask

    // Issue one instruction to dut d, starting in its FETCH cycle.
    // hs_t: cycle (relative to FETCH) at which Handshake moves away from the
    // HEI argument; negative means never.
    task automatic run_instr(input int d, input logic [11:0] ins, input int hs_t);
        logic        hei;
        logic        arg;
        int          tmo;
        int          wb;
        int          wb_hs;
        logic        to;
        logic [15:0] exp_imm;
        logic [4:0]  exp_sel;
        exp_t        e;
        obs_t        o;

        hei = ins[11] & ins[8];
        arg = ins[0];
        tmo = (d == 1) ? 8 : 0;
        to  = 1'b0;
        if (!hei) begin
            wb = 3;
        end else begin
            wb_hs = (hs_t < 0) ? 200 : ((hs_t + 3 > 4) ? hs_t + 3 : 4);
            if (tmo > 0 && wb_hs > 3 + tmo) begin
                wb = 3 + tmo;
                to = 1'b1;
            end else begin
                wb = wb_hs;
            end
        end

        exp_imm = {{10{ins[5]}}, ins[5:0]};
        if (d == 0) exp_imm = {8'h00, exp_imm[7:0]};
        exp_sel = {ins[11], ins[9], ins[8], ins[7], ins[6]};

        for (int c = 0; c <= wb; c++) begin
            e.stage   = (c == wb) ? 2'd3 : ((c >= 2) ? 2'd2 : 2'(c));
            e.pcen    = (c == wb);
            e.rw      = (c == wb) && ins[10] && !hei;
            e.accwe   = (c == 2) && !hei;
            e.waiting = hei && (c >= 3) && (c < wb);
            e.to      = (c == wb) && to;
            exp_q.push_back(e);
        end

        instr_drv[d] = ins;
        hs_drv[d]    = hei ? ((hs_t == 0) ? ~arg : arg) : 1'b0;

        for (int c = 0; c <= wb; c++) begin
            if (hei && c == hs_t && c > 0) hs_drv[d] = ~arg;
            @(negedge clk);
            e = exp_q.pop_front();
            o = obs[d];
            chk($sformatf("stage d%0d i%03h c%0d", d, ins, c), 32'(o.stage), 32'(e.stage));
            chk($sformatf("pcen d%0d i%03h c%0d", d, ins, c), 32'(o.pcen), 32'(e.pcen));
            chk($sformatf("regwrite d%0d i%03h c%0d", d, ins, c), 32'(o.rw), 32'(e.rw));
            chk($sformatf("accwe d%0d i%03h c%0d", d, ins, c), 32'(o.accwe), 32'(e.accwe));
            chk($sformatf("waiting d%0d i%03h c%0d", d, ins, c), 32'(o.waiting), 32'(e.waiting));
            chk($sformatf("timedout d%0d i%03h c%0d", d, ins, c), 32'(o.to), 32'(e.to));
            if (c == 1 || c == wb) begin
                chk($sformatf("imm d%0d i%03h c%0d", d, ins, c), 32'(o.imm), 32'(exp_imm));
                chk($sformatf("regaddr d%0d i%03h c%0d", d, ins, c), 32'(o.ra), 32'(ins[0]));
                chk($sformatf("selects d%0d i%03h c%0d", d, ins, c), 32'(o.sel), 32'(exp_sel));
            end
            @(posedge clk);
            #1;
            // IR is already latched; scribbling the bus must not matter.
            if (c == 0) instr_drv[d] = 12'($urandom);
        end
        instr_drv[d] = '0;
        $display("txn dut%0d instr=%03h hei=%0d wb_cycle=%0d timedout=%0d",
                 d, ins, hei, wb, to);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        instr_drv[0] = '0;
        instr_drv[1] = '0;
        hs_drv[0]    = 1'b0;
        hs_drv[1]    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs dut0", 32'(obs[0]), 32'd0);
        chk("reset outputs dut1", 32'(obs[1]), 32'd0);
        rst = 1'b0;

        // Plain instructions on dut0.
        run_instr(0, 12'b010001_000001, -1);  // RegWrite, UseA, reg 1
        run_instr(0, 12'b000100_100000, -1);  // Immediate E0
        run_instr(0, 12'b000100_011111, -1);  // Immediate 1F
        run_instr(0, 12'b101011_000000, -1);  // SelReg/UseMul/SelSW/UseA, not HEI

        // HEI on dut0 (unbounded wait).
        run_instr(0, 12'b100100_000000, 6);   // arg 0, handshake rises at cycle 6
        run_instr(0, 12'b110100_000001, 4);   // arg 1 with RegWrite bit set
        run_instr(0, 12'b100100_000000, 1);   // shortest possible HEI

        // dut1: wider immediate and bounded waits.
        align(1);
        run_instr(1, 12'b000100_100000, -1);  // Immediate FFE0
        run_instr(1, 12'b100100_000000, -1);  // never satisfied -> timeout
        run_instr(1, 12'b100100_000000, 8);   // satisfied on the 8th WAIT cycle
        run_instr(1, 12'b100100_000000, 9);   // one cycle too late -> timeout

        // Reset in the middle of EXEC of an ADD-type instruction.
        align(0);
        instr_drv[0] = 12'b010001_000011;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre-reset accwe dut0", 32'(obs[0].accwe), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid-exec reset dut0", 32'(obs[0]), 32'd0);
        chk("mid-exec reset dut1", 32'(obs[1]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post-reset stage dut0", 32'(obs[0].stage), 32'd0);
        run_instr(0, 12'b000000_000000, -1);  // NOP: no write may leak through

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
